mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
Memory-access pipeline stage, directly downstream of the execute stage. It registers the execute-to-memory bus and takes the synchronous data-SRAM read data that returns in its cycle. It aligns, sign- or zero-extends load data and selects the write-back value. It drives the memory-to-writeback bus and the forwarding bus to decode, and buffers load data across downstream stalls so a held load never loses its SRAM result.

Parameters:
- EX_TO_MEM_WD, 79, input bus width (shared define).
- MEM_TO_WB_WD, 70, output bus width (shared define).
- STALL_WD, 6, stall bus width (shared StallBus).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- stall  in  6  pipeline stall vector. Stop=1. Bit 3 holds this stage's input register; bit 4 is the downstream (writeback) hold.
- ex_to_mem_bus  in  79  fields, high to low:
  - pc[78:47]
  - load_type[46:44]
  - data_ram_en[43]
  - data_sram_wen[42:39]
  - sel_rf_res[38]
  - rf_we[37]
  - rf_waddr[36:32]
  - ex_result[31:0] (ALU result / data address)
- data_sram_rdata  in  32  SRAM read data, valid in the first cycle a load occupies this stage.
- mem_to_wb_bus  out  70  {pc[69:38], rf_we[37], rf_waddr[36:32], rf_wdata[31:0]}.
- mem_to_id_we  out  1  forwarding write enable.
- mem_to_id_waddr  out  5  forwarding destination register.
- mem_to_id_wdata  out  32  forwarding data, identical to rf_wdata.
- mem_adel  out  1  misaligned-load flag for the current instruction.

Behaviour:
- Input register bus_r, updated on posedge clk, in priority order:
  - rst: clear to 0.
  - stall[3]=Stop and stall[4]=NoStop: clear to 0 (bubble).
  - stall[3]=NoStop: load ex_to_mem_bus.
  - otherwise: hold.
- A zero bus is a bubble. A bubble gives rf_we=0, and all outputs derived from it are 0.
- Load data path is combinational from bus_r and the selected raw word. Latency: EX result reaches mem_to_wb_bus one cycle after EX.
- Raw word source:
  - state FRESH: data_sram_rdata.
  - state HELD: hold_q.
- Byte lane is ex_result[1:0], little-endian (lane 0 = bits 7:0). Halfword lane is ex_result[1] (0 = bits 15:0).
- load_type encoding (shared constants):
  - 000 LW
  - 001 LB: sign-extend byte
  - 010 LBU: zero-extend byte
  - 011 LH: sign-extend halfword
  - 100 LHU: zero-extend halfword
  - 101–111: treated as LW
- rf_wdata = sel_rf_res ? load_data : ex_result.
- mem_adel = data_ram_en & ~|data_sram_wen & misaligned.
  - Misaligned means: LH/LHU with ex_result[0]=1, or LW with ex_result[1:0]≠0.
  - When mem_adel=1, the output bus rf_we and mem_to_id_we are forced to 0.
- Hold FSM, two states, reset to FRESH with hold_q=0:
  - FRESH→HELD when stall[4]=Stop and stall[3]=Stop (stage held). On that same edge, hold_q <= data_sram_rdata.
  - HELD stays HELD while the stage is held. hold_q is not rewritten.
  - Any edge where bus_r loads new content or a bubble → FRESH.
  - rst in any state → FRESH, hold_q=0, bus_r=0. Reset wins over every stall combination.
- The FSM captures regardless of instruction type. Capture is harmless for non-loads because sel_rf_res=0.
- Stores pass through with rf_we=0 from EX. No data is read for stores.
- All outputs after reset: 0.

Decomposition:
- Shared defines header gets:
  - EX_TO_MEM_WD=79 and MEM_TO_WB_WD=70.
  - load_type constants LT_LW/LT_LB/LT_LBU/LT_LH/LT_LHU.
  - Stop/NoStop.
  - FSM encodings S_FRESH=1'b0, S_HELD=1'b1.
- One sub-module: load_align. It is combinational: raw word, addr[1:0] and load_type in; 32-bit extended data and misalign flag out.

Test Plan:
1. LW, ex_result=0x1000, rdata=0xDEADBEEF, no stall → next cycle rf_wdata=0xDEADBEEF, rf_we=1, waddr as sent, mem_adel=0.
2. LB at addr 0x1003, rdata=0x80FF1234 → rf_wdata=0xFFFFFF80. LBU at the same address → 0x00000080. LHU at 0x1002 → 0x000080FF.
3. LW in stage with stall[3]=stall[4]=1 for 3 cycles, rdata=0xAAAA5555 in cycle 1 then 0x0 after → rf_wdata stays 0xAAAA5555 throughout. After release, the next instruction sees FRESH.
4. stall[3]=1, stall[4]=0 for one cycle → bus_r becomes bubble: mem_to_wb_bus=0, mem_to_id_we=0.
5. LH at 0x1001 → mem_adel=1, rf_we=0 on both output buses.
6. rst asserted while in HELD holding 0x12345678 → next cycle state FRESH, hold_q=0, all outputs 0. First post-reset LW returns live rdata.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared widths, load-type codes, stall polarity and hold-FSM encodings for the memory stage.
package mem_stage_pkg;
  localparam int EX_TO_MEM_WD = 79;
  localparam int MEM_TO_WB_WD = 70;
  localparam int STALL_WD     = 6;

  localparam logic [2:0] LT_LW  = 3'b000;
  localparam logic [2:0] LT_LB  = 3'b001;
  localparam logic [2:0] LT_LBU = 3'b010;
  localparam logic [2:0] LT_LH  = 3'b011;
  localparam logic [2:0] LT_LHU = 3'b100;

  localparam logic STOP    = 1'b1;
  localparam logic NO_STOP = 1'b0;

  localparam logic [0:0] S_FRESH = 1'b0;
  localparam logic [0:0] S_HELD  = 1'b1;

  typedef struct packed {
    logic [31:0] pc;
    logic [2:0]  load_type;
    logic        data_ram_en;
    logic [3:0]  data_sram_wen;
    logic        sel_rf_res;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] ex_result;
  } ex_to_mem_t;

  typedef struct packed {
    logic [31:0] pc;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
  } mem_to_wb_t;
endpackage

// File: rtl/mem_stage_load_align.sv
// Combinational load aligner: picks the byte/halfword lane, extends it, and flags misaligned accesses.
module load_align
  import mem_stage_pkg::*;
(
  input  logic [31:0] raw,
  input  logic [1:0]  addr,
  input  logic [2:0]  load_type,
  output logic [31:0] data,
  output logic        misaligned
);
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (addr)
      2'd0:    byte_sel = raw[7:0];
      2'd1:    byte_sel = raw[15:8];
      2'd2:    byte_sel = raw[23:16];
      default: byte_sel = raw[31:24];
    endcase
    half_sel = addr[1] ? raw[31:16] : raw[15:0];
  end

  // Codes 101-111 fall into the default arm and behave exactly like LW.
  always_comb begin
    data       = raw;
    misaligned = 1'b0;
    case (load_type)
      LT_LB:  data = {{24{byte_sel[7]}}, byte_sel};
      LT_LBU: data = {24'h0, byte_sel};
      LT_LH: begin
        data       = {{16{half_sel[15]}}, half_sel};
        misaligned = addr[0];
      end
      LT_LHU: begin
        data       = {16'h0, half_sel};
        misaligned = addr[0];
      end
      default: begin
        data       = raw;
        misaligned = |addr;
      end
    endcase
  end
endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: registers the EX bus, aligns SRAM load data, and keeps the SRAM word while held.
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic [STALL_WD-1:0]     stall,
  input  logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
  input  logic [31:0]             data_sram_rdata,
  output logic [MEM_TO_WB_WD-1:0] mem_to_wb_bus,
  output logic                    mem_to_id_we,
  output logic [4:0]              mem_to_id_waddr,
  output logic [31:0]             mem_to_id_wdata,
  output logic                    mem_adel
);
  ex_to_mem_t  bus_r;
  logic [0:0]  state_q;
  logic [31:0] hold_q;
  logic [31:0] raw_word;
  logic [31:0] load_data;
  logic        misaligned;
  logic [31:0] rf_wdata;
  logic        rf_we_eff;
  logic        stage_held;
  mem_to_wb_t  wb;
  logic        unused_stall;

  assign unused_stall = ^{stall[5], stall[2:0]};
  assign stage_held   = (stall[3] == STOP) && (stall[4] == STOP);

  always_ff @(posedge clk) begin
    if (rst) begin
      bus_r   <= '0;
      state_q <= S_FRESH;
      hold_q  <= '0;
    end else begin
      if (stall[3] == STOP && stall[4] == NO_STOP) begin
        bus_r <= '0;
      end else if (stall[3] == NO_STOP) begin
        bus_r <= ex_to_mem_bus;
      end
      // The SRAM only drives the word for one cycle, so capture it on the first held edge.
      if (stage_held) begin
        if (state_q == S_FRESH) begin
          state_q <= S_HELD;
          hold_q  <= data_sram_rdata;
        end
      end else begin
        state_q <= S_FRESH;
      end
    end
  end

  assign raw_word = (state_q == S_HELD) ? hold_q : data_sram_rdata;

  load_align u_load_align (
    .raw        (raw_word),
    .addr       (bus_r.ex_result[1:0]),
    .load_type  (bus_r.load_type),
    .data       (load_data),
    .misaligned (misaligned)
  );

  assign mem_adel  = bus_r.data_ram_en & ~(|bus_r.data_sram_wen) & misaligned;
  assign rf_wdata  = bus_r.sel_rf_res ? load_data : bus_r.ex_result;
  assign rf_we_eff = bus_r.rf_we & ~mem_adel;

  assign wb.pc       = bus_r.pc;
  assign wb.rf_we    = rf_we_eff;
  assign wb.rf_waddr = bus_r.rf_waddr;
  assign wb.rf_wdata = rf_wdata;

  assign mem_to_wb_bus   = wb;
  assign mem_to_id_we    = rf_we_eff;
  assign mem_to_id_waddr = bus_r.rf_waddr;
  assign mem_to_id_wdata = rf_wdata;
endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: table of single-cycle loads/ALU/stores plus hold, bubble and reset sequences.
module tb_mem_stage;
  import mem_stage_pkg::*;

  logic        clk;
  logic        rst;
  logic [5:0]  stall;
  logic [78:0] ex_to_mem_bus;
  logic [31:0] data_sram_rdata;
  logic [69:0] mem_to_wb_bus;
  logic        mem_to_id_we;
  logic [4:0]  mem_to_id_waddr;
  logic [31:0] mem_to_id_wdata;
  logic        mem_adel;

  int n_cmp = 0;
  int n_err = 0;

  mem_stage dut (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .ex_to_mem_bus   (ex_to_mem_bus),
    .data_sram_rdata (data_sram_rdata),
    .mem_to_wb_bus   (mem_to_wb_bus),
    .mem_to_id_we    (mem_to_id_we),
    .mem_to_id_waddr (mem_to_id_waddr),
    .mem_to_id_wdata (mem_to_id_wdata),
    .mem_adel        (mem_adel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [78:0] bus;
    logic [31:0] rdata;
    logic [69:0] exp_wb;
    logic        exp_adel;
  } vec_t;

  vec_t vecs[14];

  function automatic logic [78:0] mk(input logic [31:0] pc, input logic [2:0] lt,
                                     input logic en, input logic [3:0] wen, input logic sel,
                                     input logic we, input logic [4:0] wa, input logic [31:0] res);
    return {pc, lt, en, wen, sel, we, wa, res};
  endfunction

  function automatic logic [69:0] ewb(input logic [31:0] pc, input logic we,
                                      input logic [4:0] wa, input logic [31:0] d);
    return {pc, we, wa, d};
  endfunction

  task automatic chk(input string name, input logic [69:0] act, input logic [69:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string name, input logic [69:0] exp_wb, input logic exp_adel);
    chk({name, ".wb_bus"}, mem_to_wb_bus, exp_wb);
    chk({name, ".id_we"}, {69'h0, mem_to_id_we}, {69'h0, exp_wb[37]});
    chk({name, ".id_waddr"}, {65'h0, mem_to_id_waddr}, {65'h0, exp_wb[36:32]});
    chk({name, ".id_wdata"}, {38'h0, mem_to_id_wdata}, {38'h0, exp_wb[31:0]});
    chk({name, ".adel"}, {69'h0, mem_adel}, {69'h0, exp_adel});
  endtask

  // Drive bus/stall/rst before the edge, then present the SRAM word for the cycle after it.
  task automatic step(input logic r, input logic [5:0] st, input logic [78:0] bus, input logic [31:0] rd);
    @(negedge clk);
    rst           = r;
    stall         = st;
    ex_to_mem_bus = bus;
    @(posedge clk);
    #1;
    data_sram_rdata = rd;
    #1;
  endtask

  localparam logic [5:0] ST_NONE   = 6'b000000;
  localparam logic [5:0] ST_HOLD   = 6'b011000;
  localparam logic [5:0] ST_BUBBLE = 6'b001000;

  initial begin
    vecs[0]  = '{mk(32'h100, LT_LW,  1, 4'h0, 1, 1, 5'd5,  32'h1000), 32'hDEADBEEF, ewb(32'h100, 1, 5'd5,  32'hDEADBEEF), 1'b0};
    vecs[1]  = '{mk(32'h104, LT_LB,  1, 4'h0, 1, 1, 5'd6,  32'h1003), 32'h80FF1234, ewb(32'h104, 1, 5'd6,  32'hFFFFFF80), 1'b0};
    vecs[2]  = '{mk(32'h108, LT_LBU, 1, 4'h0, 1, 1, 5'd7,  32'h1003), 32'h80FF1234, ewb(32'h108, 1, 5'd7,  32'h00000080), 1'b0};
    vecs[3]  = '{mk(32'h10C, LT_LHU, 1, 4'h0, 1, 1, 5'd8,  32'h1002), 32'h80FF1234, ewb(32'h10C, 1, 5'd8,  32'h000080FF), 1'b0};
    vecs[4]  = '{mk(32'h110, LT_LH,  1, 4'h0, 1, 1, 5'd9,  32'h1000), 32'h80FF1234, ewb(32'h110, 1, 5'd9,  32'h00001234), 1'b0};
    vecs[5]  = '{mk(32'h114, LT_LH,  1, 4'h0, 1, 1, 5'd10, 32'h1002), 32'h80FF1234, ewb(32'h114, 1, 5'd10, 32'hFFFF80FF), 1'b0};
    vecs[6]  = '{mk(32'h118, LT_LB,  1, 4'h0, 1, 1, 5'd11, 32'h1001), 32'h0000A500, ewb(32'h118, 1, 5'd11, 32'hFFFFFFA5), 1'b0};
    vecs[7]  = '{mk(32'h11C, LT_LBU, 1, 4'h0, 1, 1, 5'd12, 32'h1000), 32'h000000F7, ewb(32'h11C, 1, 5'd12, 32'h000000F7), 1'b0};
    vecs[8]  = '{mk(32'h120, LT_LW,  0, 4'h0, 0, 1, 5'd13, 32'hCAFEF00D), 32'h12345678, ewb(32'h120, 1, 5'd13, 32'hCAFEF00D), 1'b0};
    vecs[9]  = '{mk(32'h124, LT_LW,  1, 4'hF, 0, 0, 5'd0,  32'h1001), 32'h00000000, ewb(32'h124, 0, 5'd0,  32'h00001001), 1'b0};
    vecs[10] = '{mk(32'h128, LT_LH,  1, 4'h0, 1, 1, 5'd14, 32'h1001), 32'h80FF1234, ewb(32'h128, 0, 5'd14, 32'h00001234), 1'b1};
    vecs[11] = '{mk(32'h12C, LT_LW,  1, 4'h0, 1, 1, 5'd15, 32'h1002), 32'h55667788, ewb(32'h12C, 0, 5'd15, 32'h55667788), 1'b1};
    vecs[12] = '{mk(32'h130, 3'b111, 1, 4'h0, 1, 1, 5'd16, 32'h1000), 32'h01020304, ewb(32'h130, 1, 5'd16, 32'h01020304), 1'b0};
    vecs[13] = '{mk(32'h134, LT_LHU, 1, 4'h0, 1, 1, 5'd17, 32'h1003), 32'h80FF1234, ewb(32'h134, 0, 5'd17, 32'h000080FF), 1'b1};

    rst             = 1'b1;
    stall           = ST_NONE;
    ex_to_mem_bus   = '0;
    data_sram_rdata = 32'hFFFF_FFFF;
    step(1'b1, ST_NONE, mk(32'h999, LT_LW, 1, 4'h0, 1, 1, 5'd3, 32'h0), 32'hFFFF_FFFF);
    step(1'b1, ST_NONE, mk(32'h999, LT_LW, 1, 4'h0, 1, 1, 5'd3, 32'h0), 32'hFFFF_FFFF);
    chk_all("reset", 70'h0, 1'b0);

    for (int i = 0; i < 14; i++) begin
      step(1'b0, ST_NONE, vecs[i].bus, vecs[i].rdata);
      chk_all($sformatf("vec%0d", i), vecs[i].exp_wb, vecs[i].exp_adel);
    end

    // Held load keeps its captured SRAM word while the live word goes to zero.
    step(1'b0, ST_NONE, mk(32'h200, LT_LW, 1, 4'h0, 1, 1, 5'd7, 32'h2000), 32'hAAAA5555);
    chk_all("hold.c0", ewb(32'h200, 1, 5'd7, 32'hAAAA5555), 1'b0);
    for (int c = 1; c <= 3; c++) begin
      step(1'b0, ST_HOLD, mk(32'h204, LT_LW, 1, 4'h0, 1, 1, 5'd8, 32'h3000), 32'h0);
      chk_all($sformatf("hold.c%0d", c), ewb(32'h200, 1, 5'd7, 32'hAAAA5555), 1'b0);
    end
    step(1'b0, ST_NONE, mk(32'h204, LT_LW, 1, 4'h0, 1, 1, 5'd8, 32'h3000), 32'h11112222);
    chk_all("hold.release", ewb(32'h204, 1, 5'd8, 32'h11112222), 1'b0);

    step(1'b0, ST_BUBBLE, mk(32'h208, LT_LW, 1, 4'h0, 1, 1, 5'd9, 32'h3004), 32'h33334444);
    chk_all("bubble", 70'h0, 1'b0);

    // Enter HELD holding 0x12345678, then reset while the stall stays asserted.
    step(1'b0, ST_NONE, mk(32'h300, LT_LW, 1, 4'h0, 1, 1, 5'd4, 32'h4000), 32'h12345678);
    step(1'b0, ST_HOLD, mk(32'h304, LT_LW, 1, 4'h0, 1, 1, 5'd5, 32'h4004), 32'h0);
    chk_all("held_pre_rst", ewb(32'h300, 1, 5'd4, 32'h12345678), 1'b0);
    step(1'b1, ST_HOLD, mk(32'h304, LT_LW, 1, 4'h0, 1, 1, 5'd5, 32'h4004), 32'h0);
    chk_all("rst_in_held", 70'h0, 1'b0);
    chk("rst_state", {69'h0, dut.state_q}, {69'h0, S_FRESH});
    chk("rst_hold_q", {38'h0, dut.hold_q}, 70'h0);
    step(1'b0, ST_NONE, mk(32'h308, LT_LW, 1, 4'h0, 1, 1, 5'd6, 32'h4008), 32'h0BADF00D);
    chk_all("post_rst_lw", ewb(32'h308, 1, 5'd6, 32'h0BADF00D), 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
